// File: rtl/riscv_v_alu_wb_collector_if.sv
// Bundles the ALU result interface, the op descriptor channel and the VRF write port
// seen by the vector ALU write-back collector.
interface riscv_v_alu_wb_collector_if #(
    parameter int DATA_W    = 128,
    parameter int NUM_BYTES = DATA_W / 8,
    parameter int BEAT_W    = 4
);
    logic                 op_valid;
    logic                 op_ready;
    logic [4:0]           op_vd;
    logic [BEAT_W-1:0]    op_num_beats;
    logic                 op_mask_mode;
    logic [NUM_BYTES-1:0] op_last_be;

    logic                 res_valid;
    logic                 res_ready;
    logic [DATA_W-1:0]    res_data;
    logic [NUM_BYTES-1:0] res_zf;
    logic [NUM_BYTES-1:0] res_of;
    logic [NUM_BYTES-1:0] res_cf;

    logic                 wb_valid;
    logic                 wb_ready;
    logic [4:0]           wb_vd;
    logic [BEAT_W-1:0]    wb_beat;
    logic [DATA_W-1:0]    wb_data;
    logic [NUM_BYTES-1:0] wb_be;

    logic                 busy;
    logic                 done;
    logic [NUM_BYTES-1:0] sum_zf;
    logic [NUM_BYTES-1:0] sum_of;
    logic [NUM_BYTES-1:0] sum_cf;

    // Environment side: issues descriptors and result beats, accepts VRF writes.
    modport master (
        output op_valid, op_vd, op_num_beats, op_mask_mode, op_last_be,
        output res_valid, res_data, res_zf, res_of, res_cf,
        output wb_ready,
        input  op_ready, res_ready,
        input  wb_valid, wb_vd, wb_beat, wb_data, wb_be,
        input  busy, done, sum_zf, sum_of, sum_cf
    );

    // Collector side.
    modport slave (
        input  op_valid, op_vd, op_num_beats, op_mask_mode, op_last_be,
        input  res_valid, res_data, res_zf, res_of, res_cf,
        input  wb_ready,
        output op_ready, res_ready,
        output wb_valid, wb_vd, wb_beat, wb_data, wb_be,
        output busy, done, sum_zf, sum_of, sum_cf
    );
endinterface

// File: rtl/riscv_v_alu_wb_collector.sv
// Vector ALU write-back collector: streams result beats to the VRF through a 2-entry
// skid buffer (data mode) or packs per-byte carries into one mask write (mask mode).
module riscv_v_alu_wb_collector #(
    parameter int DATA_W    = 128,
    parameter int NUM_BYTES = DATA_W / 8,
    parameter int MAX_BEATS = DATA_W / NUM_BYTES,
    parameter int BEAT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    riscv_v_alu_wb_collector_if.slave bus
);

    localparam logic [BEAT_W-1:0] MAX_BEATS_B = BEAT_W'(MAX_BEATS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FLUSH   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Mask packing only has room for MAX_BEATS groups of NUM_BYTES carry bits.
    function automatic logic [BEAT_W-1:0] sat_beats(input logic [BEAT_W-1:0] n);
        return (n > MAX_BEATS_B) ? MAX_BEATS_B : n;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;

    logic [4:0]           r_vd;
    logic [BEAT_W-1:0]    r_num;
    logic                 r_mask_mode;
    logic [NUM_BYTES-1:0] r_last_be;
    logic [BEAT_W-1:0]    r_rx_cnt;
    logic [DATA_W-1:0]    r_mask_acc;
    logic [NUM_BYTES-1:0] r_sum_zf;
    logic [NUM_BYTES-1:0] r_sum_of;
    logic [NUM_BYTES-1:0] r_sum_cf;

    logic [DATA_W-1:0]    r_buf_data [2];
    logic [BEAT_W-1:0]    r_buf_beat [2];
    logic [NUM_BYTES-1:0] r_buf_be   [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_buf_cnt;

    logic                 w_op_fire;
    logic                 w_rx_left;
    logic                 w_buf_full;
    logic                 w_res_rdy;
    logic                 w_res_fire;
    logic                 w_enq;
    logic                 w_buf_vld;
    logic                 w_deq;
    logic                 w_drained;
    logic [BEAT_W-1:0]    w_num_sat;
    logic [BEAT_W-1:0]    w_last_idx;

    assign w_num_sat  = sat_beats(bus.op_num_beats);
    assign w_op_fire  = bus.op_valid && (r_state == S_IDLE);
    assign w_rx_left  = (r_rx_cnt < r_num);
    assign w_buf_full = (r_buf_cnt == 2'd2);
    assign w_res_rdy  = (r_state == S_COLLECT) && w_rx_left && (r_mask_mode || !w_buf_full);
    assign w_res_fire = bus.res_valid && w_res_rdy;
    assign w_enq      = w_res_fire && !r_mask_mode;
    assign w_buf_vld  = (r_state == S_COLLECT) && !r_mask_mode && (r_buf_cnt != 2'd0);
    assign w_deq      = w_buf_vld && bus.wb_ready;
    // Leaving COLLECT in the same cycle the last buffered beat is written saves a cycle.
    assign w_drained  = (r_buf_cnt == 2'd0) || ((r_buf_cnt == 2'd1) && w_deq);
    assign w_last_idx = r_num - BEAT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.op_ready  = 1'b0;
        bus.res_ready = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_vd     = '0;
        bus.wb_beat   = '0;
        bus.wb_data   = '0;
        bus.wb_be     = '0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        bus.sum_zf    = '0;
        bus.sum_of    = '0;
        bus.sum_cf    = '0;

        case (r_state)
            S_IDLE: begin
                bus.busy     = 1'b0;
                bus.op_ready = 1'b1;
                if (bus.op_valid) begin
                    w_state_nxt = (w_num_sat == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                bus.res_ready = w_res_rdy;
                if (r_mask_mode) begin
                    if (!w_rx_left) begin
                        w_state_nxt = S_FLUSH;
                    end
                end else begin
                    if (w_buf_vld) begin
                        bus.wb_valid = 1'b1;
                        bus.wb_vd    = r_vd;
                        bus.wb_beat  = r_buf_beat[r_rd_ptr];
                        bus.wb_data  = r_buf_data[r_rd_ptr];
                        bus.wb_be    = r_buf_be[r_rd_ptr];
                    end
                    if (!w_rx_left && w_drained) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_FLUSH: begin
                bus.wb_valid = 1'b1;
                bus.wb_vd    = r_vd;
                bus.wb_data  = r_mask_acc;
                bus.wb_be    = '1;
                if (bus.wb_ready) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.done    = 1'b1;
                bus.sum_zf  = r_sum_zf;
                bus.sum_of  = r_sum_of;
                bus.sum_cf  = r_sum_cf;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Descriptor, beat counter, mask and flag accumulators, skid-buffer pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vd        <= '0;
            r_num       <= '0;
            r_mask_mode <= 1'b0;
            r_last_be   <= '0;
            r_rx_cnt    <= '0;
            r_mask_acc  <= '0;
            r_sum_zf    <= '0;
            r_sum_of    <= '0;
            r_sum_cf    <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_buf_cnt   <= 2'd0;
        end else begin
            if (w_op_fire) begin
                r_vd        <= bus.op_vd;
                r_num       <= w_num_sat;
                r_mask_mode <= bus.op_mask_mode;
                r_last_be   <= bus.op_last_be;
                r_rx_cnt    <= '0;
                r_mask_acc  <= '0;
                r_sum_zf    <= '0;
                r_sum_of    <= '0;
                r_sum_cf    <= '0;
            end else if (w_res_fire) begin
                r_rx_cnt <= r_rx_cnt + BEAT_W'(1);
                r_sum_zf <= r_sum_zf | bus.res_zf;
                r_sum_of <= r_sum_of | bus.res_of;
                r_sum_cf <= r_sum_cf | bus.res_cf;
                if (r_mask_mode) begin
                    for (int b = 0; b < MAX_BEATS; b++) begin
                        if (r_rx_cnt == BEAT_W'(b)) begin
                            r_mask_acc[b*NUM_BYTES +: NUM_BYTES] <= bus.res_cf;
                        end
                    end
                end
            end

            if (w_enq) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_buf_cnt <= r_buf_cnt + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    // Skid-buffer payload; only ever observed through a non-zero occupancy.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_buf_data[r_wr_ptr] <= bus.res_data;
            r_buf_beat[r_wr_ptr] <= r_rx_cnt;
            r_buf_be[r_wr_ptr]   <= (r_rx_cnt == w_last_idx) ? r_last_be : '1;
        end
    end

endmodule

// File: doc/riscv_v_alu_wb_collector.md
Name: riscv_v_alu_wb_collector

Overview:
- Consumer end of the vector arithmetic ALU result interface: accepts per-beat result data and per-byte zf/of/cf, and drives the vector register-file write port.
- Per-op descriptor selects one of two modes. Data mode writes each beat to the vector register. Mask mode packs per-byte carry bits into one mask register write (vmadc/vmsbc style).
- Sits between ALU output stage and VRF write arbiter, with backpressure on both sides.

Parameters:
- DATA_W, 128, ALU datapath width (RISCV_V_DATA_WIDTH).
- NUM_BYTES, DATA_W/8, bytes per beat (RISCV_V_NUM_BYTES_DATA).
- MAX_BEATS, DATA_W/NUM_BYTES (8), max beats per op; bound by mask packing.
- BEAT_W, 4, width of beat count/index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- op_valid  in  1  descriptor valid.
- op_ready  out  1  descriptor accepted when op_valid && op_ready.
- op_vd  in  5  destination vector register.
- op_num_beats  in  BEAT_W  beats in op, 0..15.
- op_mask_mode  in  1  1 = pack res_cf into mask; 0 = write res_data.
- op_last_be  in  NUM_BYTES  byte enables for final beat (tail).
- res_valid  in  1  ALU result beat valid.
- res_ready  out  1  result beat accepted on res_valid && res_ready.
- res_data  in  DATA_W  ALU result data.
- res_zf, res_of, res_cf  in  NUM_BYTES each  per-byte ALU flags.
- wb_valid  out  1  VRF write request.
- wb_ready  in  1  VRF write accepted on wb_valid && wb_ready.
- wb_vd  out  5  write register.
- wb_beat  out  BEAT_W  beat index within register group.
- wb_data  out  DATA_W  write data.
- wb_be  out  NUM_BYTES  byte enables.
- busy  out  1  op in progress.
- done  out  1  one-cycle pulse at op completion.
- sum_zf, sum_of, sum_cf  out  NUM_BYTES each  sticky OR of flags over the op; valid while done=1.

Behaviour:
- Reset (async assert, sync deassert):
  - State = IDLE; skid buffer emptied; counters and accumulators cleared.
  - op_ready=1, res_ready=0, wb_valid=0, busy=0, done=0.
  - All data, flag and wb address outputs are 0.
- Assertion mid-op drops all buffered beats and pending writes. No write may issue in the cycle after deassertion.
- Descriptor latching:
  - op_num_beats above MAX_BEATS saturates to MAX_BEATS.
  - op_num_beats = 0: no res beats accepted, no writes; go IDLE -> DONE directly.
- States:
  - IDLE: op_ready=1, res_ready=0. Handshake latches descriptor and clears accumulators, then goes to COLLECT (or DONE if zero beats).
  - COLLECT:
    - op_ready=0.
    - rx_cnt counts accepted res beats.
    - res_ready=1 while rx_cnt < num_beats and the 2-entry skid buffer is not full. In mask mode the buffer is unused and res_ready=1 whenever rx_cnt < num_beats.
    - Exit when rx_cnt==num_beats and, in data mode, all buffered beats are written. Data mode goes to DONE; mask mode goes to FLUSH.
  - FLUSH (mask mode only):
    - wb_valid=1, wb_vd=vd, wb_beat=0, wb_data=mask accumulator, wb_be all ones.
    - Hold all wb outputs stable until wb_ready, then go to DONE.
  - DONE: done=1 for exactly one cycle, sum_* valid; then IDLE. op_ready=0 in DONE.
- Data mode:
  - Accepted beat k is enqueued into the skid buffer. wb_valid rises the cycle after acceptance (latency 1) if the buffer was empty.
  - wb_beat=k, wb_data=res_data of beat k.
  - wb_be all ones, except beat num_beats-1 uses op_last_be.
  - Writes issue strictly in beat order.
  - wb_* is held stable while wb_valid && !wb_ready.
  - Same-cycle enqueue and dequeue keeps occupancy unchanged. Full buffer forces res_ready=0.
- Mask mode:
  - Beat k sets mask_acc[k*NUM_BYTES +: NUM_BYTES] = res_cf. res_data is ignored.
  - Bits of beats not received stay 0.
- Flags:
  - Each accepted beat ORs res_zf/of/cf into sum_zf/of/cf.
  - sum_* outputs are 0 outside DONE.
- busy=1 in COLLECT, FLUSH and DONE.
- A descriptor offered during an op waits; op_ready returns to 1 in the IDLE cycle after done.

Test Plan:
- Data mode, vd=4, 3 beats, data 0x11.., 0x22.., 0x33.., last_be=0x00FF, wb_ready=1 → 3 writes (beats 0,1,2), each one cycle after acceptance. Beat 2 has be=0x00FF, the others 0xFFFF. done pulses after the third write.
- Data mode, 4 beats with wb_ready=0 for 5 cycles → res_ready drops after 2 beats are buffered; wb_* stays stable; no beat is lost or reordered once wb_ready=1.
- Mask mode, vd=0, 2 beats with res_cf=0xA5A5 then 0x0F0F → one write, wb_beat=0, wb_data[31:0]=0x0F0FA5A5, upper bits 0, wb_be=0xFFFF.
- Flags, 3 beats with res_zf=0x0001, 0x0100, 0x0000 → sum_zf=0x0101 during the done cycle; sum_* is 0 in the cycles before and after.
- op_num_beats=0, then op_num_beats=12 in mask mode → first op: done with no wb_valid and res_ready never 1. Second op: exactly 8 beats accepted.
- rst_n asserted with 1 beat buffered and wb_valid=1 → wb_valid=0 immediately. After release the state is IDLE and op_ready=1; a new op then writes only its own beats.
